// File: rtl/cnn_window_gen.sv
// cnn_window_gen: buffers one CH-channel IMG_W x IMG_H frame, then emits one
// 3x3 SAME-size window per pixel in raster order of the centre pixel.
// Optional feature macro: CNN_WINDOW_REPLICATE_PAD_EN. When it is defined,
// pad_mode=1 selects replicate (edge-clamp) padding. When it is undefined,
// pad_mode is ignored and out-of-frame taps are always zero.
module cnn_window_gen #(
    parameter int DATA_W = 32,
    parameter int CH     = 2,
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*DATA_W-1:0]     in_data,
    input  logic                     pad_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH*9*DATA_W-1:0]   out_win,
    output logic                     out_last
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = $clog2(NPIX);
    localparam int PIX_W = CH * DATA_W;
    localparam int WIN_W = CH * 9 * DATA_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t            state_r;
    logic [AW-1:0]     pix_cnt_r;
    logic [AW-1:0]     win_idx_r;
    logic              pad_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [WIN_W-1:0]  out_win_r;
    logic [PIX_W-1:0]  mem_r [NPIX];

    logic              in_fire_s;
    logic              out_fire_s;
    logic              fwd_s;
    logic [AW-1:0]     sel_idx_s;
    logic [WIN_W-1:0]  win_next_s;

`ifdef CNN_WINDOW_REPLICATE_PAD_EN
    // Clamp a tap coordinate into [0, hi]
    function automatic int clamp_coord(input int v, input int hi);
        if (v < 0) begin
            return 0;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction
`else
    logic unused_pad_s;
    assign unused_pad_s = pad_r;
`endif

    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && out_ready;
    // The final pixel lands in storage on the same edge window 0 is registered,
    // so that beat is forwarded straight into the window assembly.
    assign fwd_s      = (state_r == ST_LOAD) && in_fire_s;
    // Window being prepared for the next output register load
    assign sel_idx_s  = (state_r == ST_EMIT) ? (win_idx_r + AW'(1)) : '0;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_win   = out_win_r;
    assign out_last  = out_last_r;

    // Pixel storage: write each accepted beat at the current pixel address
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            mem_r[pix_cnt_r] <= in_data;
        end
    end

    // Assemble the window centred on sel_idx_s from storage plus the forwarded beat
    always_comb begin
        int               row;
        int               col;
        int               rr;
        int               cc;
        int               addr_i;
        logic             use_pix;
        logic [AW-1:0]    addr;
        logic [PIX_W-1:0] pix;
        win_next_s = '0;
        row = int'(sel_idx_s) / IMG_W;
        col = int'(sel_idx_s) % IMG_W;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                rr      = row + ky - 1;
                cc      = col + kx - 1;
                use_pix = (rr >= 0) && (rr < IMG_H) && (cc >= 0) && (cc < IMG_W);
                addr_i  = rr * IMG_W + cc;
`ifdef CNN_WINDOW_REPLICATE_PAD_EN
                if (pad_r) begin
                    addr_i  = clamp_coord(rr, IMG_H - 1) * IMG_W + clamp_coord(cc, IMG_W - 1);
                    use_pix = 1'b1;
                end else begin
                    addr_i  = rr * IMG_W + cc;
                end
`endif
                addr = AW'(addr_i);
                if (fwd_s && (addr == pix_cnt_r)) begin
                    pix = in_data;
                end else begin
                    pix = mem_r[addr];
                end
                for (int c = 0; c < CH; c++) begin
                    if (use_pix) begin
                        win_next_s[(c*9 + ky*3 + kx)*DATA_W +: DATA_W] = pix[c*DATA_W +: DATA_W];
                    end else begin
                        win_next_s[(c*9 + ky*3 + kx)*DATA_W +: DATA_W] = '0;
                    end
                end
            end
        end
    end

    // Control FSM: load a frame, then stream its windows, with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pix_cnt_r   <= '0;
            win_idx_r   <= '0;
            pad_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_win_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_fire_s) begin
                        pad_r     <= pad_mode;
                        pix_cnt_r <= AW'(1);
                        state_r   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_fire_s) begin
                        if (pix_cnt_r == LAST_IDX) begin
                            state_r     <= ST_EMIT;
                            pix_cnt_r   <= '0;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            win_idx_r   <= '0;
                            out_win_r   <= win_next_s;
                            out_last_r  <= 1'b0;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + AW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_fire_s) begin
                        if (win_idx_r == LAST_IDX) begin
                            state_r     <= ST_IDLE;
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            win_idx_r   <= '0;
                        end else begin
                            win_idx_r  <= win_idx_r + AW'(1);
                            out_win_r  <= win_next_s;
                            out_last_r <= ((win_idx_r + AW'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    pix_cnt_r   <= '0;
                    win_idx_r   <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: a default 5x5x2 instance and a 4x3x1 instance.
`timescale 1ns/1ps
module tb_cnn_window_gen;
    localparam int DW   = 32;
    localparam int A_W  = 5;
    localparam int A_H  = 5;
    localparam int A_C  = 2;
    localparam int B_W  = 4;
    localparam int B_H  = 3;
    localparam int B_C  = 1;
    localparam int WMAX = 2 * 9 * DW;
`ifdef CNN_WINDOW_REPLICATE_PAD_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic                  a_in_valid = 1'b0, a_in_ready, a_pad = 1'b0;
    logic                  a_out_valid, a_out_ready = 1'b1, a_out_last;
    logic [A_C*DW-1:0]     a_in_data = '0;
    logic [A_C*9*DW-1:0]   a_out_win;
    logic                  b_in_valid = 1'b0, b_in_ready, b_pad = 1'b0;
    logic                  b_out_valid, b_out_ready = 1'b1, b_out_last;
    logic [B_C*DW-1:0]     b_in_data = '0;
    logic [B_C*9*DW-1:0]   b_out_win;

    int total = 0;
    int bad   = 0;
    logic [WMAX-1:0] exp_q[$];
    bit              last_q[$];
    logic [WMAX-1:0] got_q[$];

    always #5 clk = ~clk;

    cnn_window_gen #(.DATA_W(DW), .CH(A_C), .IMG_W(A_W), .IMG_H(A_H)) dut (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .pad_mode(a_pad), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_win(a_out_win), .out_last(a_out_last)
    );

    cnn_window_gen #(.DATA_W(DW), .CH(B_C), .IMG_W(B_W), .IMG_H(B_H)) dut_small (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .pad_mode(b_pad), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_win(b_out_win), .out_last(b_out_last)
    );

    // Reference window: pixel i of channel ch carries base+i+1+100*ch
    function automatic logic [WMAX-1:0] model_win(input int base, input int w, input int h,
                                                   input int nch, input bit pad, input int idx);
        logic [WMAX-1:0] v;
        int r, c, rr, cc, val;
        v = '0;
        r = idx / w;
        c = idx % w;
        for (int ch = 0; ch < nch; ch++) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    rr = r + ky - 1;
                    cc = c + kx - 1;
                    if ((rr < 0 || rr >= h || cc < 0 || cc >= w) && !(pad && REPL)) begin
                        val = 0;
                    end else begin
                        if (rr < 0) rr = 0;
                        if (rr > h - 1) rr = h - 1;
                        if (cc < 0) cc = 0;
                        if (cc > w - 1) cc = w - 1;
                        val = base + rr * w + cc + 1 + 100 * ch;
                    end
                    v[(ch*9 + ky*3 + kx)*DW +: DW] = val;
                end
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] pix_data(input int base, input int p);
        logic [63:0] d;
        d[31:0]  = base + p + 1;
        d[63:32] = base + p + 101;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input bit sel, input bit v, input logic [63:0] d, input bit pad);
        if (sel) begin
            b_in_valid = v; b_in_data = d[31:0]; b_pad = pad;
        end else begin
            a_in_valid = v; a_in_data = d; a_pad = pad;
        end
    endtask

    // Present nbeats pixels (optional idle gaps) and queue the frame's windows
    task automatic send_frame(input bit sel, input int base, input bit pad, input int nbeats, input bit gaps);
        int w, h, nch, t;
        logic rdy, ov;
        w   = sel ? B_W : A_W;
        h   = sel ? B_H : A_H;
        nch = sel ? B_C : A_C;
        for (int p = 0; p < nbeats; p++) begin
            if (gaps && (p % 3 == 2)) begin
                drive_in(sel, 1'b0, 64'd0, pad);
                tick();
                tick();
            end
            drive_in(sel, 1'b1, pix_data(base, p), pad);
            t = 0;
            rdy = sel ? b_in_ready : a_in_ready;
            while (rdy !== 1'b1 && t < 20) begin
                tick();
                t++;
                rdy = sel ? b_in_ready : a_in_ready;
            end
            ov = sel ? b_out_valid : a_out_valid;
            total++;
            if (t >= 20 || ov !== 1'b0) begin
                bad++;
                $display("FAIL load_beat p=%0d: in_ready=%b out_valid=%b, required in_ready=1 out_valid=0",
                         p, rdy, ov);
            end
            tick();
        end
        drive_in(sel, 1'b0, 64'd0, pad);
        if (nbeats == w * h) begin
            for (int i = 0; i < w * h; i++) begin
                exp_q.push_back(model_win(base, w, h, nch, pad, i));
                last_q.push_back(i == w * h - 1);
            end
        end
    endtask

    // Accept n windows, optionally stalling 1,0,0,1 and driving junk beats
    task automatic collect(input bit sel, input int n, input bit stall, input bit garbage);
        int got, t;
        bit rdy;
        logic ov, ol, ir;
        logic [WMAX-1:0] ow;
        got = 0;
        t   = 0;
        while (got < n && t < 4 * n + 50) begin
            rdy = stall ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            if (sel) b_out_ready = rdy; else a_out_ready = rdy;
            if (garbage) drive_in(sel, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0);
            ov = sel ? b_out_valid : a_out_valid;
            ol = sel ? b_out_last : a_out_last;
            ir = sel ? b_in_ready : a_in_ready;
            ow = sel ? WMAX'(b_out_win) : a_out_win;
            if (ov === 1'b1) begin
                total += 3;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_window: got a window, required none");
                    got = n;
                end else begin
                    if (ow !== exp_q[0]) begin
                        bad++;
                        $display("FAIL window #%0d: got %h required %h", got, ow, exp_q[0]);
                    end
                    if (ol !== last_q[0]) begin
                        bad++;
                        $display("FAIL out_last #%0d: got %b required %b", got, ol, last_q[0]);
                    end
                    if (ir !== 1'b0) begin
                        bad++;
                        $display("FAIL in_ready_emit #%0d: got %b required 0", got, ir);
                    end
                    if (rdy) begin
                        got_q.push_back(ow);
                        void'(exp_q.pop_front());
                        void'(last_q.pop_front());
                        got++;
                    end
                end
            end
            tick();
            t++;
        end
        drive_in(sel, 1'b0, 64'd0, 1'b0);
        if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL collect_count: got %0d windows required %0d", got, n);
        end
    endtask

    task automatic check_frame_end(input bit sel);
        logic ir, ov;
        ir = sel ? b_in_ready : a_in_ready;
        ov = sel ? b_out_valid : a_out_valid;
        total++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            bad++;
            $display("FAIL frame_end: in_ready=%b out_valid=%b required 1 and 0", ir, ov);
        end
    endtask

    task automatic check_latency(input bit sel);
        logic ir, ov;
        ir = sel ? b_in_ready : a_in_ready;
        ov = sel ? b_out_valid : a_out_valid;
        total++;
        if (ov !== 1'b1 || ir !== 1'b0) begin
            bad++;
            $display("FAIL latency: out_valid=%b in_ready=%b required 1 and 0", ov, ir);
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        total += 2;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_out_win !== '0) begin
            bad++;
            $display("FAIL reset_a: in_ready=%b out_valid=%b out_last=%b win=%h required 1 0 0 0",
                     a_in_ready, a_out_valid, a_out_last, a_out_win);
        end
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_last !== 1'b0 || b_out_win !== '0) begin
            bad++;
            $display("FAIL reset_b: in_ready=%b out_valid=%b out_last=%b win=%h required 1 0 0 0",
                     b_in_ready, b_out_valid, b_out_last, b_out_win);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        last_q.delete();
    endtask

    task automatic test_reset();
        #1;
        rst_pulse();
    endtask

    task automatic test_zero_pad();
        int e0[9]  = '{0, 0, 0, 0, 1, 2, 0, 6, 7};
        int e24[9] = '{19, 20, 0, 24, 25, 0, 0, 0, 0};
        got_q.delete();
        send_frame(1'b0, 0, 1'b0, 25, 1'b0);
        check_latency(1'b0);
        collect(1'b0, 25, 1'b0, 1'b0);
        check_frame_end(1'b0);
        total++;
        if (got_q.size() != 25) begin
            bad++;
            $display("FAIL zero_pad_count: got %0d required 25", got_q.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                total += 2;
                if (got_q[0][k*DW +: DW] !== DW'(e0[k])) begin
                    bad++;
                    $display("FAIL zp_win0 k=%0d: got %0d required %0d", k, got_q[0][k*DW +: DW], e0[k]);
                end
                if (got_q[24][k*DW +: DW] !== DW'(e24[k])) begin
                    bad++;
                    $display("FAIL zp_win24 k=%0d: got %0d required %0d", k, got_q[24][k*DW +: DW], e24[k]);
                end
            end
        end
    endtask

    task automatic test_pad_mode();
        int erep[9]  = '{1, 1, 2, 1, 1, 2, 6, 6, 7};
        int ezero[9] = '{0, 0, 0, 0, 1, 2, 0, 6, 7};
        int e12[9]   = '{107, 108, 109, 112, 113, 114, 117, 118, 119};
        int ex;
        got_q.delete();
        send_frame(1'b0, 0, 1'b1, 25, 1'b0);
        collect(1'b0, 25, 1'b0, 1'b0);
        check_frame_end(1'b0);
        total++;
        if (got_q.size() != 25) begin
            bad++;
            $display("FAIL pad_count: got %0d required 25", got_q.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                ex = REPL ? erep[k] : ezero[k];
                total += 2;
                if (got_q[0][k*DW +: DW] !== DW'(ex)) begin
                    bad++;
                    $display("FAIL pad_win0 k=%0d: got %0d required %0d", k, got_q[0][k*DW +: DW], ex);
                end
                if (got_q[12][(9+k)*DW +: DW] !== DW'(e12[k])) begin
                    bad++;
                    $display("FAIL pad_win12_ch1 k=%0d: got %0d required %0d", k, got_q[12][(9+k)*DW +: DW], e12[k]);
                end
            end
        end
    endtask

    task automatic test_stall_garbage();
        send_frame(1'b0, 50, 1'b0, 25, 1'b0);
        collect(1'b0, 25, 1'b1, 1'b1);
        check_frame_end(1'b0);
        send_frame(1'b0, 0, 1'b0, 25, 1'b0);
        collect(1'b0, 25, 1'b0, 1'b0);
        check_frame_end(1'b0);
    endtask

    task automatic test_reset_mid();
        send_frame(1'b0, 7, 1'b0, 10, 1'b0);
        rst_pulse();
        got_q.delete();
        send_frame(1'b0, 0, 1'b0, 25, 1'b0);
        check_latency(1'b0);
        collect(1'b0, 1, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 1 || got_q[0][4*DW +: DW] !== 32'd1 || got_q[0][8*DW +: DW] !== 32'd7) begin
            bad++;
            $display("FAIL reset_mid_win0: got %h required centre 1 and corner 7", got_q[0]);
        end
        collect(1'b0, 2, 1'b0, 1'b0);
        rst_pulse();
        send_frame(1'b0, 20, 1'b1, 25, 1'b0);
        collect(1'b0, 25, 1'b0, 1'b0);
        check_frame_end(1'b0);
    endtask

    task automatic test_back_to_back();
        send_frame(1'b1, 0, 1'b0, 12, 1'b1);
        check_latency(1'b1);
        collect(1'b1, 12, 1'b0, 1'b0);
        check_frame_end(1'b1);
        send_frame(1'b1, 300, 1'b1, 12, 1'b0);
        check_latency(1'b1);
        collect(1'b1, 12, 1'b1, 1'b0);
        check_frame_end(1'b1);
    endtask

    initial begin
        test_reset();
        test_zero_pad();
        test_pad_mode();
        test_stall_garbage();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
